// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl: fetch port, data port, memory port and
// the busy flag. The controller takes the slave view; requesters and the
// memory sit on the master side.
interface mem_access_ctrl_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  // Instruction-fetch port (read-only)
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic [DW-1:0] f_rdata;
  // Data port (LOAD/STORE)
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  // Single-port synchronous memory
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // Status
  logic          busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, f_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_ack, f_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates the fetch and data ports onto a
// single-port synchronous memory through the MAR/MBR register pair.
// Each access is a fixed IDLE -> ADDR -> WAIT -> RESP sequence, so one
// access completes every four cycles. All outputs are registered.
module mem_access_ctrl #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  state_t        state_q;
  logic [AW-1:0] mar_q;
  logic [DW-1:0] mbr_q;
  logic          owner_q;
  logic          we_q;
  logic          last_q;
  logic          f_ack_q;
  logic          d_ack_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic          busy_q;

  logic          any_req_s;
  logic          win_data_s;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    any_req_s  = bus.f_req | bus.d_req;
    win_data_s = 1'b0;
    if (bus.f_req && bus.d_req) begin
      win_data_s = (last_q == PORT_FETCH);
    end else if (bus.d_req) begin
      win_data_s = 1'b1;
    end else begin
      win_data_s = 1'b0;
    end
  end

  // Access sequencer: latches MAR/MBR, drives the memory for one cycle,
  // captures read data and pulses the owner's ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mar_q    <= {AW{1'b0}};
      mbr_q    <= {DW{1'b0}};
      owner_q  <= PORT_FETCH;
      we_q     <= 1'b0;
      last_q   <= PORT_FETCH;
      f_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_s) begin
            if (win_data_s) begin
              mar_q <= bus.d_addr;
              mbr_q <= bus.d_wdata;
            end else begin
              mar_q <= bus.f_addr;
            end
            // The fetch port can never write, whatever d_we says.
            we_q     <= win_data_s & bus.d_we;
            owner_q  <= win_data_s;
            mem_en_q <= 1'b1;
            mem_we_q <= win_data_s & bus.d_we;
            busy_q   <= 1'b1;
            state_q  <= S_ADDR;
          end
        end
        S_ADDR: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // Stores keep MBR so d_rdata reflects the stored word.
          if (!we_q) begin
            mbr_q <= bus.mem_rdata;
          end
          f_ack_q <= (owner_q == PORT_FETCH);
          d_ack_q <= (owner_q == PORT_DATA);
          state_q <= S_RESP;
        end
        S_RESP: begin
          f_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          f_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.f_ack     = f_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.f_rdata   = mbr_q;
  assign bus.d_rdata   = mbr_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mar_q;
  assign bus.mem_wdata = mbr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a behavioural 4096x16
// synchronous memory.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Backdoor preload port into the memory model
  logic        bd_we   = 1'b0;
  logic [11:0] bd_addr = 12'h000;
  logic [15:0] bd_data = 16'h0000;
  logic [15:0] mem [0:4095];

  mem_access_ctrl_if #(.AW(12), .DW(16)) bus ();

  mem_access_ctrl #(.AW(12), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter for grant spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port memory with one-cycle read latency
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // One access on a port; called at a negedge, returns at a negedge.
  task automatic run_access(input logic dp, input logic we, input logic [11:0] addr,
                            input logic [15:0] wd, output logic [15:0] rd,
                            output int lat, output int we_cnt,
                            output logic en1, output logic [11:0] adr1,
                            output logic other);
    logic got;
    if (dp) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.f_req = 1'b1; bus.f_addr = addr;
    end
    lat = 0; we_cnt = 0; en1 = 1'b0; adr1 = 12'h000; other = 1'b0; got = 1'b0;
    while (!got && lat < 16) begin
      @(negedge clk);
      lat++;
      if (bus.mem_we) we_cnt++;
      if (lat == 1) begin
        en1  = bus.mem_en;
        adr1 = bus.mem_addr;
      end
      if (dp ? bus.f_ack : bus.d_ack) other = 1'b1;
      got = dp ? bus.d_ack : bus.f_ack;
    end
    rd = dp ? bus.d_rdata : bus.f_rdata;
    bus.d_req = 1'b0;
    bus.f_req = 1'b0;
    check_eq("ack_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    check_eq("ack_one_cycle", {31'd0, (dp ? bus.d_ack : bus.f_ack)}, 32'd0);
    check_eq("busy_after", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    int          lat, we_cnt, busy_cnt;
    logic        en1, other, ack_seen;
    logic [11:0] adr1;
    int          ack_cyc [4];
    logic        who;
    logic [15:0] cap;

    bus.f_req = 1'b0; bus.f_addr = 12'h000;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 12'h000; bus.d_wdata = 16'h0000;

    // Preload while held in reset
    @(negedge clk);
    preload(12'h000, 16'h1004);
    preload(12'h010, 16'h1111);
    preload(12'h020, 16'hCAFE);

    // Reset state
    check_eq("rst_f_ack",   {31'd0, bus.f_ack},  32'd0);
    check_eq("rst_d_ack",   {31'd0, bus.d_ack},  32'd0);
    check_eq("rst_mem_en",  {31'd0, bus.mem_en}, 32'd0);
    check_eq("rst_mem_we",  {31'd0, bus.mem_we}, 32'd0);
    check_eq("rst_busy",    {31'd0, bus.busy},   32'd0);
    check_eq("rst_addr",    {20'd0, bus.mem_addr},  32'd0);
    check_eq("rst_wdata",   {16'd0, bus.mem_wdata}, 32'd0);
    check_eq("rst_rdata",   {16'd0, bus.d_rdata},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of ADDR of a store: write must be suppressed
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h010; bus.d_wdata = 16'hBEEF;
    @(posedge clk);
    #1;
    check_eq("midrst_we_before", {31'd0, bus.mem_we}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_we",    {31'd0, bus.mem_we}, 32'd0);
    check_eq("midrst_en",    {31'd0, bus.mem_en}, 32'd0);
    check_eq("midrst_busy",  {31'd0, bus.busy},   32'd0);
    check_eq("midrst_addr",  {20'd0, bus.mem_addr}, 32'd0);
    check_eq("midrst_rdata", {16'd0, bus.d_rdata},  32'd0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.d_ack) ack_seen = 1'b1;
    end
    check_eq("midrst_no_ack", {31'd0, ack_seen}, 32'd0);
    check_eq("midrst_mem", {16'd0, mem[12'h010]}, 32'h1111);

    // Store then load at 0x123
    run_access(1'b1, 1'b1, 12'h123, 16'hA5A5, rd, lat, we_cnt, en1, adr1, other);
    check_eq("st_lat",   lat, 32'd3);
    check_eq("st_we",    we_cnt, 32'd1);
    check_eq("st_rdata", {16'd0, rd}, 32'hA5A5);
    check_eq("st_fack",  {31'd0, other}, 32'd0);
    check_eq("st_mem",   {16'd0, mem[12'h123]}, 32'hA5A5);
    run_access(1'b1, 1'b0, 12'h123, 16'h0000, rd, lat, we_cnt, en1, adr1, other);
    check_eq("ld_lat",   lat, 32'd3);
    check_eq("ld_we",    we_cnt, 32'd0);
    check_eq("ld_rdata", {16'd0, rd}, 32'hA5A5);

    // Fetch from 0x000; d_we high must not turn it into a write
    bus.d_we = 1'b1;
    run_access(1'b0, 1'b0, 12'h000, 16'h0000, rd, lat, we_cnt, en1, adr1, other);
    bus.d_we = 1'b0;
    check_eq("fe_lat",   lat, 32'd3);
    check_eq("fe_rdata", {16'd0, rd}, 32'h1004);
    check_eq("fe_dack",  {31'd0, other}, 32'd0);
    check_eq("fe_we",    we_cnt, 32'd0);
    check_eq("fe_en",    {31'd0, en1}, 32'd1);

    // Boundary address 0xFFF
    run_access(1'b1, 1'b1, 12'hFFF, 16'h7777, rd, lat, we_cnt, en1, adr1, other);
    check_eq("bd_addr",  {20'd0, adr1}, 32'hFFF);
    check_eq("bd_we",    we_cnt, 32'd1);
    run_access(1'b1, 1'b0, 12'hFFF, 16'h0000, rd, lat, we_cnt, en1, adr1, other);
    check_eq("bd_rdata", {16'd0, rd}, 32'h7777);

    // Early drop: d_req held for one cycle only
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h020;
    @(negedge clk);
    bus.d_req = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    ack_seen = 1'b0;
    cap = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.d_ack) begin
        ack_seen = 1'b1;
        cap = bus.d_rdata;
      end
    end
    check_eq("drop_ack",   {31'd0, ack_seen}, 32'd1);
    check_eq("drop_busy",  busy_cnt, 32'd3);
    check_eq("drop_rdata", {16'd0, cap}, 32'hCAFE);

    // Round-robin tie with both requests held from reset
    bus.f_req = 1'b1; bus.f_addr = 12'h000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h123;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      ack_seen = 1'b0;
      who = 1'b0;
      while (!ack_seen && w < 12) begin
        @(negedge clk);
        w++;
        if (bus.d_ack || bus.f_ack) begin
          ack_seen = 1'b1;
          who = bus.d_ack;
          ack_cyc[k] = cyc;
          cap = who ? bus.d_rdata : bus.f_rdata;
        end
      end
      check_eq("rr_ack_seen", {31'd0, ack_seen}, 32'd1);
      check_eq("rr_order", {31'd0, who}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("rr_rdata", {16'd0, cap}, (k % 2 == 0) ? 32'hA5A5 : 32'h1004);
      if (k > 0) check_eq("rr_spacing", ack_cyc[k] - ack_cyc[k-1], 32'd4);
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences all accesses to the 4096×16 main memory through the MAR/MBR register pair and shares that memory between two requesters: the instruction-fetch port (read-only) and the data port (LOAD/STORE, read or write). It replaces per-instruction direct memory writes with one arbitrated, multi-cycle MAR→memory→MBR sequence. It sits between the control unit/datapath and the single-port synchronous memory.

## Interface
- AW, 12, address width; MAR width; memory depth 2^AW
- DW, 16, data width; MBR, AC and memory word width
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  AW  fetch address (PC)
- f_ack  out  1  one-cycle pulse: fetch complete, f_rdata valid
- f_rdata  out  DW  fetched word (= MBR)
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address (X)
- d_wdata  in  DW  store data (AC)
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DW  loaded word (= MBR)
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address (= MAR)
- mem_wdata  out  DW  memory write data (= MBR)
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Registers: MAR (AW), MBR (DW), owner (0 = fetch, 1 = data), we_q, last (last port served), state.
- States: IDLE, ADDR, WAIT, RESP.
- IDLE: if no request, stay. Else pick winner: single requester wins; both requesting → port ≠ last. Latch MAR←winner addr, MBR←d_wdata if data port else unchanged, we_q←d_we & (winner = data), owner←winner → ADDR.
- ADDR: mem_en=1, mem_we=we_q, mem_addr=MAR, mem_wdata=MBR → WAIT.
- WAIT: if !we_q, MBR←mem_rdata; stores leave MBR unchanged → RESP.
- RESP: ack of owner high, last←owner → IDLE.
- mem_en/mem_we high only in ADDR; both 0 in all other states.
- f_rdata and d_rdata both continuously = MBR; valid only when own ack is high. After a store, d_rdata = stored word.
- Fetch port never writes; f_req treated as read regardless of d_we.
- Requester dropping req after grant: transaction still completes, ack still pulses.
- Req still high on the cycle after ack is a new request.
- Requests arriving while busy wait; no queue beyond held req lines.

## Timing
- Reset (async): state=IDLE, MAR=0, MBR=0, owner=0, we_q=0, last=fetch (so data port wins first tie); all outputs 0 (f_ack, d_ack, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata).
- Latency: req high at edge E in IDLE → ADDR after E, memory access sampled at E+1, MBR loaded at E+2, ack high during cycle E+2→E+3, IDLE after E+3.
- Throughput: one access per 4 cycles; back-to-back requests granted at edge E+4.
- Acks are registered decodes of state (no combinational path from req to ack).
- Reset mid-transaction: abort immediately, no ack issued; a write in ADDR is suppressed if rst asserts before the ADDR-ending edge.
- Address wrap: none; all AW bits pass through unchanged (0xFFF valid).

## Test plan
- Reset: assert rst mid-ADDR of a store to 0x010 with 0xBEEF → mem_we drops asynchronously, all outputs 0, M[0x010] unchanged.
- Store then load: d_req, d_we=1, d_addr=0x123, d_wdata=0xA5A5 → mem_we pulse at E+1, d_ack at E+2, d_rdata=0xA5A5; then load 0x123 → d_ack with d_rdata=0xA5A5, mem_we never high.
- Fetch: memory preloaded M[0x000]=0x1004; f_req, f_addr=0x000 → f_ack one cycle at E+2, f_rdata=0x1004, d_ack stays 0.
- Tie round-robin: both req held from reset → order data, fetch, data, fetch; grants 4 cycles apart; no starvation.
- Boundary address: store 0x7777 to 0xFFF, load 0xFFF → 0x7777; mem_addr=0xFFF during ADDR.
- Early drop: d_req pulsed 1 cycle (load 0x020) → d_ack still pulses, busy high exactly 3 cycles after grant edge.
